note_sequencer: RTL and testbench

Record/replay scheduler for the piano tone generator. Sits between the PS/2 keyboard decoder and the key-code-to-period lookup. It passes live key codes through, records them as timed segments into an internal buffer, and replays a stored melody by driving the tone generator's key-code input. Live keys take priority during replay.

---
 rtl/note_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: record/replay scheduler between the keyboard decoder and the
// key-code-to-period lookup. Live keys pass through; recording stores timed
// {code, duration} segments; replay drives stored codes with live-key override.
module note_sequencer #(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 8
) (
  input  logic                   clk_5MHz,
  input  logic                   reset,
  input  logic [7:0]             key_in,
  input  logic                   record,
  input  logic                   replay,
  output logic [7:0]             key_out,
  output logic [1:0]             mode,
  output logic                   full,
  output logic [$clog2(DEPTH):0] length
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = 8 + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [CW-1:0]    TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PTR_FULL  = PW'(DEPTH);
  localparam logic [PW-1:0]    PTR_LAST  = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_REPLAY = 2'd2
  } state_t;

  // Tick-credited duration; a full segment holds at max (the saturation write
  // then restarts the count at one).
  function automatic logic [DUR_W-1:0] dur_sat_inc(input logic [DUR_W-1:0] d,
                                                   input logic t);
    if (t && (d != DUR_MAX)) return d + 1'b1;
    return d;
  endfunction

  state_t            state_q;
  logic              rec_s_q, rec_p_q, rep_s_q, rep_p_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, length_q;
  logic [7:0]        cur_code_q, key_out_q;
  logic [DUR_W-1:0]  dur_q, el_q;
  logic              fill_q, drain_q, full_q;

  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     rdata_q;
  logic [AW-1:0]     addr;
  logic [EW-1:0]     wdata;
  logic              we, wr_last, sat_wr, seg_close;
  logic              tick, rec_edge, rep_edge;
  logic [DUR_W-1:0]  dur_close;
  logic [7:0]        rd_code;
  logic [DUR_W-1:0]  rd_dur;

  assign tick      = (cnt_q == TICK_LAST);
  assign rec_edge  = rec_s_q & ~rec_p_q;
  assign rep_edge  = rep_s_q & ~rep_p_q;
  assign dur_close = dur_sat_inc(dur_q, tick);
  assign seg_close = rec_edge || (key_in != cur_code_q);
  assign sat_wr    = tick && (dur_q == DUR_MAX);
  assign wdata     = {cur_code_q, dur_close};
  assign addr      = (state_q == S_RECORD) ? wr_ptr_q[AW-1:0] : rd_ptr_q[AW-1:0];
  assign wr_last   = we && (wr_ptr_q == PTR_LAST);
  assign rd_code   = rdata_q[EW-1:DUR_W];
  assign rd_dur    = rdata_q[DUR_W-1:0];

  // Segment write strobe: closed segments with zero ticks are dropped.
  always_comb begin
    we = 1'b0;
    if (reset && (state_q == S_RECORD)) begin
      if (seg_close) we = (dur_close != '0);
      else           we = sat_wr;
    end
  end

  // Single-port segment buffer with registered read (block-RAM friendly).
  always_ff @(posedge clk_5MHz) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  // Mode FSM, tick divider, button edge detection and all registered outputs.
  always_ff @(posedge clk_5MHz) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rec_s_q    <= 1'b0;
      rec_p_q    <= 1'b0;
      rep_s_q    <= 1'b0;
      rep_p_q    <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      length_q   <= '0;
      cur_code_q <= 8'h00;
      key_out_q  <= 8'h00;
      dur_q      <= '0;
      el_q       <= '0;
      fill_q     <= 1'b0;
      drain_q    <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      rec_s_q <= record;
      rec_p_q <= rec_s_q;
      rep_s_q <= replay;
      rep_p_q <= rep_s_q;
      cnt_q   <= tick ? '0 : cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          key_out_q <= key_in;
          if (rec_edge) begin
            state_q    <= S_RECORD;
            wr_ptr_q   <= '0;
            full_q     <= 1'b0;
            cur_code_q <= key_in;
            dur_q      <= '0;
            cnt_q      <= '0;
          end else if (rep_edge && (length_q != '0)) begin
            state_q  <= S_REPLAY;
            rd_ptr_q <= '0;
            el_q     <= '0;
            fill_q   <= 1'b1;
            drain_q  <= 1'b0;
            cnt_q    <= '0;
          end
        end
        S_RECORD: begin
          key_out_q <= key_in;
          if (we) wr_ptr_q <= wr_ptr_q + 1'b1;
          if (wr_last) begin
            full_q   <= 1'b1;
            length_q <= PTR_FULL;
            state_q  <= S_IDLE;
          end else if (rec_edge) begin
            length_q <= we ? wr_ptr_q + 1'b1 : wr_ptr_q;
            state_q  <= S_IDLE;
          end else if (key_in != cur_code_q) begin
            cur_code_q <= key_in;
            dur_q      <= '0;
          end else if (sat_wr) begin
            dur_q <= DUR_W'(1);
          end else begin
            dur_q <= dur_close;
          end
        end
        S_REPLAY: begin
          if (rep_edge) begin
            state_q   <= S_IDLE;
            key_out_q <= key_in;
          end else begin
            // The read port lags the entry pointer by one clock; fill_q covers
            // the first entry, drain_q holds the last entry for its final clock.
            fill_q <= 1'b0;
            if (fill_q)              key_out_q <= key_in;
            else if (key_in != 8'h00) key_out_q <= key_in;
            else                      key_out_q <= rd_code;
            if (drain_q) begin
              state_q <= S_IDLE;
            end else if (tick) begin
              if (el_q + 1'b1 == rd_dur) begin
                el_q <= '0;
                if (rd_ptr_q + 1'b1 == length_q) drain_q  <= 1'b1;
                else                             rd_ptr_q <= rd_ptr_q + 1'b1;
              end else begin
                el_q <= el_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_out = key_out_q;
  assign mode    = state_q;
  assign full    = full_q;
  assign length  = length_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed vector table, hand-written corner
// sequences and randomized stimulus, all checked against a schedule-level model.
module tb_note_sequencer;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 4;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int DMAX     = (1 << DUR_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [7:0]    key_i = 8'h00;
  logic          rec_i = 1'b0;
  logic          rep_i = 1'b0;
  logic [7:0]    key_o;
  logic [1:0]    mode_o;
  logic          full_o;
  logic [LW-1:0] len_o;

  note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .clk_5MHz(clk), .reset(rst_n), .key_in(key_i), .record(rec_i),
    .replay(rep_i), .key_out(key_o), .mode(mode_o), .full(full_o),
    .length(len_o)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Model state: outputs, button history, recorded segments, replay start.
  int m_n = 0, m_anchor = 0, m_mode = 0, m_ko = 0, m_full = 0, m_len = 0;
  bit m_rh1 = 0, m_rh2 = 0, m_ph1 = 0, m_ph2 = 0;
  int m_cur = 0, m_dur = 0, m_cnt = 0, m_t0 = 0;
  int m_code [DEPTH];
  int m_d    [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic push_seg(input int c, input int d);
    m_code[m_cnt] = c;
    m_d[m_cnt]    = d;
    m_cnt++;
    if (m_cnt == DEPTH) begin
      m_full = 1;
      m_len  = DEPTH;
      m_mode = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    bit re, pe, tk;
    int d, tot, el, pos, k, acc, ki;
    m_n++;
    ki = int'(key_i);
    if (!rst_n) begin
      m_mode = 0; m_ko = 0; m_full = 0; m_len = 0;
      m_rh1 = 0; m_rh2 = 0; m_ph1 = 0; m_ph2 = 0;
      m_anchor = m_n;
      return;
    end
    re = m_rh1 && !m_rh2;
    pe = m_ph1 && !m_ph2;
    m_rh2 = m_rh1; m_rh1 = rec_i;
    m_ph2 = m_ph1; m_ph1 = rep_i;
    tk = (m_n > m_anchor) && (((m_n - m_anchor) % TICK_DIV) == 0);
    case (m_mode)
      0: begin
        m_ko = ki;
        if (re) begin
          m_mode = 1; m_cnt = 0; m_full = 0; m_cur = ki; m_dur = 0; m_anchor = m_n;
        end else if (pe && m_len > 0) begin
          m_mode = 2; m_t0 = m_n; m_anchor = m_n;
        end
      end
      1: begin
        m_ko = ki;
        if (re || ki != m_cur) begin
          d = m_dur + ((tk && m_dur < DMAX) ? 1 : 0);
          if (d > 0) push_seg(m_cur, d);
          if (m_mode == 1) begin
            if (re) begin
              m_mode = 0; m_len = m_cnt;
            end else begin
              m_cur = ki; m_dur = 0;
            end
          end
        end else if (tk) begin
          if (m_dur == DMAX) begin
            push_seg(m_cur, DMAX);
            m_dur = 1;
          end else begin
            m_dur++;
          end
        end
      end
      default: begin
        if (pe) begin
          m_mode = 0; m_ko = ki;
        end else begin
          tot = 0;
          for (int i = 0; i < m_len; i++) tot += m_d[i];
          el = m_n - m_t0;
          if (el < 2) begin
            m_ko = ki;
          end else begin
            pos = (el - 2) / TICK_DIV;
            k = 0; acc = m_d[0];
            while (pos >= acc && k < m_len - 1) begin
              k++;
              acc += m_d[k];
            end
            m_ko = (ki != 0) ? ki : m_code[k];
          end
          if (el == TICK_DIV * tot + 1) m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic check_model();
    chk("model_key_out", 32'(key_o),  m_ko);
    chk("model_mode",    32'(mode_o), m_mode);
    chk("model_full",    32'(full_o), m_full);
    chk("model_length",  32'(len_o),  m_len);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] key;
    logic       rec, rep, rst;
    int         n;
    logic [7:0] ko;
    logic [1:0] md;
    int         len;
    logic       fl;
  } vec_t;

  vec_t tbl [21];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Pass-through, then record 41x12 / 00x8 / 5Ax16 and replay it.
    tbl[0]  = '{8'h00, 1'b0, 1'b0, 1'b0,  2, 8'h00, 2'd0, 0, 1'b0};
    tbl[1]  = '{8'h41, 1'b0, 1'b0, 1'b1,  1, 8'h41, 2'd0, 0, 1'b0};
    tbl[2]  = '{8'h41, 1'b1, 1'b0, 1'b1,  1, 8'h41, 2'd0, 0, 1'b0};
    tbl[3]  = '{8'h41, 1'b1, 1'b0, 1'b1,  1, 8'h41, 2'd1, 0, 1'b0};
    tbl[4]  = '{8'h41, 1'b0, 1'b0, 1'b1, 11, 8'h41, 2'd1, 0, 1'b0};
    tbl[5]  = '{8'h00, 1'b0, 1'b0, 1'b1,  8, 8'h00, 2'd1, 0, 1'b0};
    tbl[6]  = '{8'h5A, 1'b0, 1'b0, 1'b1, 15, 8'h5A, 2'd1, 0, 1'b0};
    tbl[7]  = '{8'h5A, 1'b1, 1'b0, 1'b1,  1, 8'h5A, 2'd1, 0, 1'b0};
    tbl[8]  = '{8'h00, 1'b1, 1'b0, 1'b1,  1, 8'h00, 2'd0, 3, 1'b0};
    tbl[9]  = '{8'h00, 1'b0, 1'b0, 1'b1,  2, 8'h00, 2'd0, 3, 1'b0};
    tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b1,  1, 8'h00, 2'd0, 3, 1'b0};
    tbl[11] = '{8'h00, 1'b0, 1'b1, 1'b1,  1, 8'h00, 2'd2, 3, 1'b0};
    tbl[12] = '{8'h00, 1'b0, 1'b0, 1'b1,  1, 8'h00, 2'd2, 3, 1'b0};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b1,  1, 8'h41, 2'd2, 3, 1'b0};
    tbl[14] = '{8'h00, 1'b0, 1'b0, 1'b1, 11, 8'h41, 2'd2, 3, 1'b0};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b1,  1, 8'h00, 2'd2, 3, 1'b0};
    tbl[16] = '{8'h00, 1'b0, 1'b0, 1'b1,  7, 8'h00, 2'd2, 3, 1'b0};
    tbl[17] = '{8'h00, 1'b0, 1'b0, 1'b1,  1, 8'h5A, 2'd2, 3, 1'b0};
    tbl[18] = '{8'h00, 1'b0, 1'b0, 1'b1, 14, 8'h5A, 2'd2, 3, 1'b0};
    tbl[19] = '{8'h00, 1'b0, 1'b0, 1'b1,  1, 8'h5A, 2'd0, 3, 1'b0};
    tbl[20] = '{8'h33, 1'b0, 1'b0, 1'b1,  1, 8'h33, 2'd0, 3, 1'b0};

    @(negedge clk);
    for (int r = 0; r < 21; r++) begin
      key_i = tbl[r].key; rec_i = tbl[r].rec; rep_i = tbl[r].rep; rst_n = tbl[r].rst;
      repeat (tbl[r].n) cyc();
      chk($sformatf("tbl%0d_key_out", r), 32'(key_o),  32'(tbl[r].ko));
      chk($sformatf("tbl%0d_mode", r),    32'(mode_o), 32'(tbl[r].md));
      chk($sformatf("tbl%0d_length", r),  32'(len_o),  32'(tbl[r].len));
      chk($sformatf("tbl%0d_full", r),    32'(full_o), 32'(tbl[r].fl));
    end

    // Saturation (20 ticks -> 15 + 5) and discarded one-cycle blips.
    key_i = 8'h22; rec_i = 1'b1; cyc(); cyc();
    chk("sat_enter_mode", 32'(mode_o), 1);
    rec_i = 1'b0; repeat (79) cyc();
    key_i = 8'h66; cyc();
    key_i = 8'h00; cyc();
    rec_i = 1'b1; cyc(); cyc();
    chk("sat_length", 32'(len_o), 2);
    chk("sat_mode", 32'(mode_o), 0);
    rec_i = 1'b0; cyc();
    rep_i = 1'b1; cyc(); cyc();
    chk("sat_replay_mode", 32'(mode_o), 2);
    rep_i = 1'b0; cyc(); cyc();
    chk("sat_first_code", 32'(key_o), 32'h22);
    repeat (79) cyc();
    chk("sat_last_code", 32'(key_o), 32'h22);
    chk("sat_end_mode", 32'(mode_o), 0);
    cyc();
    chk("sat_pass_through", 32'(key_o), 32'h00);

    // Buffer full after the fourth write.
    key_i = 8'h10; rec_i = 1'b1; cyc(); cyc();
    rec_i = 1'b0; repeat (3) cyc();
    for (int i = 1; i <= 3; i++) begin
      key_i = 8'(8'h10 + i);
      repeat (4) cyc();
    end
    chk("full_before_mode", 32'(mode_o), 1);
    chk("full_before_full", 32'(full_o), 0);
    key_i = 8'h14; cyc();
    chk("full_mode", 32'(mode_o), 0);
    chk("full_flag", 32'(full_o), 1);
    chk("full_length", 32'(len_o), 4);
    key_i = 8'h15; repeat (4) cyc();
    chk("full_idle_key", 32'(key_o), 32'h15);

    // Live override keeps timing; replay edge aborts.
    key_i = 8'h00; rep_i = 1'b1; cyc(); cyc();
    rep_i = 1'b0; cyc(); cyc();
    chk("ovr_code0", 32'(key_o), 32'h10);
    cyc();
    key_i = 8'h51; cyc();
    chk("ovr_live_a", 32'(key_o), 32'h51);
    cyc(); cyc();
    chk("ovr_live_b", 32'(key_o), 32'h51);
    key_i = 8'h00; cyc();
    chk("ovr_resume", 32'(key_o), 32'h11);
    rep_i = 1'b1; cyc();
    chk("abort_pre_mode", 32'(mode_o), 2);
    cyc();
    chk("abort_mode", 32'(mode_o), 0);
    rep_i = 1'b0; cyc();

    // Reset mid-replay, then a replay press with nothing stored.
    rep_i = 1'b1; cyc(); cyc();
    rep_i = 1'b0; repeat (3) cyc();
    chk("rst_pre_key", 32'(key_o), 32'h10);
    rst_n = 1'b0; cyc();
    chk("rst_key_out", 32'(key_o), 0);
    chk("rst_length", 32'(len_o), 0);
    chk("rst_mode", 32'(mode_o), 0);
    rst_n = 1'b1; cyc();
    rep_i = 1'b1; cyc(); cyc();
    rep_i = 1'b0; cyc();
    chk("rst_replay_ignored", 32'(mode_o), 0);

    // Simultaneous record and replay edges: record wins.
    key_i = 8'h77; rec_i = 1'b1; rep_i = 1'b1; cyc(); cyc();
    chk("both_mode", 32'(mode_o), 1);
    rec_i = 1'b0; rep_i = 1'b0; repeat (6) cyc();
    rec_i = 1'b1; cyc(); cyc();
    rec_i = 1'b0; cyc();
    chk("both_end_mode", 32'(mode_o), 0);
    chk("both_length", 32'(len_o), 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0)
        key_i = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rec_i = ($urandom_range(0, 59) == 0) ? 1'b1 : (rec_i & 1'($urandom_range(0, 1)));
      rep_i = ($urandom_range(0, 79) == 0) ? 1'b1 : (rep_i & 1'($urandom_range(0, 1)));
      rst_n = ($urandom_range(0, 1499) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
